crc5_req_arbiter: RTL

//  Shares one CRC5 engine between NREQ token builders.

---
 rtl/crc5_req_arbiter_if.sv | 30 +++
 rtl/crc5_req_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/crc5_req_arbiter_if.sv
// Bundle between the token-packet builders / CRC5 engine (master side)
// and the round-robin arbiter that shares the engine (slave side).
interface crc5_req_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 11
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [4:0]         rsp_crc;
    logic               rsp_err;
    logic               eng_start;
    logic [DW-1:0]      eng_data;
    logic               eng_rec;
    logic               eng_computing;
    logic               eng_done;
    logic [4:0]         eng_crc;
    logic [7:0]         err_cnt;

    modport master (
        output req, req_data, eng_computing, eng_done, eng_crc,
        input  gnt, rsp_valid, rsp_crc, rsp_err, eng_start, eng_data, eng_rec, err_cnt
    );

    modport slave (
        input  req, req_data, eng_computing, eng_done, eng_crc,
        output gnt, rsp_valid, rsp_crc, rsp_err, eng_start, eng_data, eng_rec, err_cnt
    );
endinterface

// File: rtl/crc5_req_arbiter.sv
// Round-robin arbiter sharing one CRC5 engine between NREQ token builders;
// drives the engine start/rec handshake and returns CRC or timeout per requester.
module crc5_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 11,
    parameter int TIMEOUT = 64
) (
    input logic                 clk,
    input logic                 rst_n,
    crc5_req_arbiter_if.slave   bus
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   g;
    logic [7:0]      cnt;
    logic            busy_seen;

    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic [4:0]      rsp_crc_q;
    logic            rsp_err_q;
    logic            eng_start_q;
    logic [DW-1:0]   eng_data_q;
    logic            eng_rec_q;
    logic [7:0]      err_cnt_q;

    logic [IW-1:0]   pick;
    logic [DW-1:0]   sel_data;
    logic            abort;

    // First set request at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pick     = rr_ptr;
        sel_data = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[(int'(rr_ptr) + k) % NREQ]) pick = IW'((int'(rr_ptr) + k) % NREQ);
        end
        for (int k = 0; k < NREQ; k++) begin
            if (pick == IW'(k)) sel_data = bus.req_data[k*DW +: DW];
        end
    end

    // An engine that never reports busy within two cycles of start is treated as timed out.
    assign abort = (cnt == 8'(TIMEOUT - 1)) ||
                   (cnt == 8'd1 && !busy_seen && !bus.eng_computing);

    // NOTE: async reset; all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            g           <= '0;
            cnt         <= '0;
            busy_seen   <= 1'b0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_crc_q   <= '0;
            rsp_err_q   <= 1'b0;
            eng_start_q <= 1'b0;
            eng_data_q  <= '0;
            eng_rec_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        g           <= pick;
                        eng_data_q  <= sel_data;
                        gnt_q       <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                        eng_start_q <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    eng_start_q <= 1'b0;
                    cnt         <= '0;
                    busy_seen   <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: begin
                    busy_seen <= busy_seen | bus.eng_computing;
                    if (bus.eng_done) begin
                        rsp_crc_q   <= bus.eng_crc;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= gnt_q;
                        eng_rec_q   <= 1'b1;
                        state       <= ACK;
                    end else if (abort) begin
                        rsp_crc_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= gnt_q;
                        eng_rec_q   <= 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                        state       <= ACK;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ACK: begin
                    rsp_valid_q <= '0;
                    eng_rec_q   <= 1'b0;
                    gnt_q       <= '0;
                    rr_ptr      <= (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_crc   = rsp_crc_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.eng_start = eng_start_q;
    assign bus.eng_data  = eng_data_q;
    assign bus.eng_rec   = eng_rec_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule
